// File: rtl/reward_update_engine.sv
// Reward update sequencer: writes node ID to the cluster table, copies NUM_WORDS Q-values into the
// action's packet slot, then appends a cluster-ID trailer. Optional index check: REWARD_BOUNDS_CHECK_EN.
module reward_update_engine #(
    parameter int WORD_WIDTH   = 16,
    parameter int ADDR_WIDTH   = 11,
    parameter int STRIDE_SHIFT = 1,
    parameter logic [ADDR_WIDTH-1:0] NODE_BASE = 11'h148,
    parameter logic [ADDR_WIDTH-1:0] QVAL_BASE = 11'h1C8,
    parameter logic [ADDR_WIDTH-1:0] PKT_BASE  = 11'h048,
    parameter int NUM_WORDS    = 4,
    parameter int RD_LAT       = 1,
    parameter int MAX_IDX      = 64
) (
    input  logic                  clock,
    input  logic                  nrst,
    input  logic                  start,
    input  logic [WORD_WIDTH-1:0] my_node_id,
    input  logic [WORD_WIDTH-1:0] my_cluster_id,
    input  logic [WORD_WIDTH-1:0] action,
    input  logic [WORD_WIDTH-1:0] besthop,
    input  logic [WORD_WIDTH-1:0] mem_rdata,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [WORD_WIDTH-1:0] mem_wdata,
    output logic                  mem_we,
    output logic                  mem_re,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    // state   | meaning
    // IDLE    | waiting for start, all outputs low
    // WR_NODE | write node ID into cluster table
    // RD_REQ  | issue Q-value read for word i
    // RD_WAIT | wait RD_LAT cycles, capture on the last one
    // WR_PKT  | write captured word into packet slot, advance i
    // WR_TRL  | write cluster-ID trailer
    // DONE    | one-cycle completion pulse
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_WR_NODE = 3'd1;
    localparam logic [2:0] S_RD_REQ  = 3'd2;
    localparam logic [2:0] S_RD_WAIT = 3'd3;
    localparam logic [2:0] S_WR_PKT  = 3'd4;
    localparam logic [2:0] S_WR_TRL  = 3'd5;
    localparam logic [2:0] S_DONE    = 3'd6;

    localparam int IW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [31:0] SLOT_WORDS = 32'(NUM_WORDS + 1);
    localparam logic [31:0] TRL_OFS    = 32'(NUM_WORDS);

    logic [2:0]            state, nxt_state;
    logic [IW-1:0]         word_i, nxt_i;
    logic [CW-1:0]         wait_cnt, nxt_wait;
    logic [WORD_WIDTH-1:0] node_q, cluster_q, action_q, besthop_q;
    logic [WORD_WIDTH-1:0] eff_node, eff_cluster, eff_action, eff_besthop;
    logic                  err_q, nxt_err, idx_bad;
    logic [ADDR_WIDTH-1:0] nxt_addr;
    logic [WORD_WIDTH-1:0] nxt_wdata;
    logic                  nxt_we, nxt_re;
    logic [31:0]           slot_idx;

    function automatic logic [ADDR_WIDTH-1:0] addr_of(input logic [ADDR_WIDTH-1:0] base,
                                                      input logic [31:0] idx);
        logic [31:0] sum;
        sum = 32'(base) + (idx << STRIDE_SHIFT);
        return sum[ADDR_WIDTH-1:0];
    endfunction

`ifdef REWARD_BOUNDS_CHECK_EN
    localparam logic [31:0] LAST_OFS = 32'(NUM_WORDS - 1);
    localparam logic [31:0] MAX_U    = 32'(MAX_IDX);
    assign idx_bad = (32'(my_cluster_id) >= MAX_U) ||
                     ((32'(besthop) + LAST_OFS) >= MAX_U) ||
                     (32'(action) >= MAX_U);
`else
    assign idx_bad = 1'b0;
`endif

    always_comb begin
        nxt_state   = state;
        nxt_i       = word_i;
        nxt_wait    = wait_cnt;
        nxt_err     = err_q;
        eff_node    = node_q;
        eff_cluster = cluster_q;
        eff_action  = action_q;
        eff_besthop = besthop_q;
        case (state)
            S_IDLE: begin
                if (start) begin
                    eff_node    = my_node_id;
                    eff_cluster = my_cluster_id;
                    eff_action  = action;
                    eff_besthop = besthop;
                    nxt_i       = '0;
                    nxt_err     = idx_bad;
                    nxt_state   = idx_bad ? S_DONE : S_WR_NODE;
                end
            end
            S_WR_NODE: nxt_state = S_RD_REQ;
            S_RD_REQ: begin
                nxt_state = S_RD_WAIT;
                nxt_wait  = CW'(RD_LAT - 1);
            end
            S_RD_WAIT: begin
                if (wait_cnt == '0) nxt_state = S_WR_PKT;
                else                nxt_wait  = wait_cnt - CW'(1);
            end
            S_WR_PKT: begin
                nxt_i     = word_i + IW'(1);
                nxt_state = (word_i == IW'(NUM_WORDS - 1)) ? S_WR_TRL : S_RD_REQ;
            end
            S_WR_TRL: nxt_state = S_DONE;
            S_DONE:   nxt_state = S_IDLE;
            default:  nxt_state = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they are registered yet valid in their own state.
    always_comb begin
        slot_idx  = 32'(eff_action) * SLOT_WORDS;
        nxt_addr  = '0;
        nxt_wdata = '0;
        nxt_we    = 1'b0;
        nxt_re    = 1'b0;
        case (nxt_state)
            S_WR_NODE: begin
                nxt_addr  = addr_of(NODE_BASE, 32'(eff_cluster));
                nxt_wdata = eff_node;
                nxt_we    = 1'b1;
            end
            S_RD_REQ: begin
                nxt_addr = addr_of(QVAL_BASE, 32'(eff_besthop) + 32'(nxt_i));
                nxt_re   = 1'b1;
            end
            S_WR_PKT: begin
                nxt_addr  = addr_of(PKT_BASE, slot_idx + 32'(nxt_i));
                nxt_wdata = mem_rdata;
                nxt_we    = 1'b1;
            end
            S_WR_TRL: begin
                nxt_addr  = addr_of(PKT_BASE, slot_idx + TRL_OFS);
                nxt_wdata = eff_cluster;
                nxt_we    = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge nrst) begin
        if (!nrst) begin
            state     <= S_IDLE;
            word_i    <= '0;
            wait_cnt  <= '0;
            node_q    <= '0;
            cluster_q <= '0;
            action_q  <= '0;
            besthop_q <= '0;
            err_q     <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_we    <= 1'b0;
            mem_re    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= nxt_state;
            word_i    <= nxt_i;
            wait_cnt  <= nxt_wait;
            node_q    <= eff_node;
            cluster_q <= eff_cluster;
            action_q  <= eff_action;
            besthop_q <= eff_besthop;
            err_q     <= nxt_err;
            mem_addr  <= nxt_addr;
            mem_wdata <= nxt_wdata;
            mem_we    <= nxt_we;
            mem_re    <= nxt_re;
            busy      <= (nxt_state != S_IDLE) && (nxt_state != S_DONE);
            done      <= (nxt_state == S_DONE);
        end
    end

    assign err = err_q;

endmodule

// File: tb/tb_reward_update_engine.sv
// Scoreboard bench for reward_update_engine: a transaction-level model predicts every memory access
// and the done pulse; a monitor thread compares them as the DUT presents them.
module tb_reward_update_engine;

    localparam int          WW  = 16;
    localparam int          AW  = 11;
    localparam int          S   = 1;
    localparam int unsigned NB  = 32'h148;
    localparam int unsigned QB  = 32'h1C8;
    localparam int unsigned PB  = 32'h048;
    localparam int          NW  = 4;
    localparam int          RL  = 1;
    localparam int unsigned MI  = 64;
    localparam int          LAT = 3 + NW * (RL + 2);

    logic          clock = 1'b0;
    logic          nrst;
    logic          start;
    logic [WW-1:0] my_node_id, my_cluster_id, action, besthop;
    logic [WW-1:0] mem_rdata;
    logic [AW-1:0] mem_addr;
    logic [WW-1:0] mem_wdata;
    logic          mem_we, mem_re, busy, done, err;

    reward_update_engine #(
        .WORD_WIDTH(WW), .ADDR_WIDTH(AW), .STRIDE_SHIFT(S),
        .NODE_BASE(11'h148), .QVAL_BASE(11'h1C8), .PKT_BASE(11'h048),
        .NUM_WORDS(NW), .RD_LAT(RL), .MAX_IDX(64)
    ) dut (
        .clock(clock), .nrst(nrst), .start(start),
        .my_node_id(my_node_id), .my_cluster_id(my_cluster_id),
        .action(action), .besthop(besthop), .mem_rdata(mem_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [WW-1:0] init_val(input logic [AW-1:0] a);
        int v;
        v = int'(a) * 40503 + 4660;
        return v[15:0];
    endfunction

    // Memory model: writes on the clock edge, read data appears RL cycles after the re cycle.
    logic [WW-1:0] tb_mem [2048];
    bit            tb_wr  [2048];
    logic          pv [RL];
    logic [AW-1:0] pa [RL];

    always @(posedge clock) begin
        if (mem_we) begin
            tb_mem[mem_addr] <= mem_wdata;
            tb_wr[mem_addr]  <= 1'b1;
        end
        pv[0] <= mem_re;
        pa[0] <= mem_addr;
        for (int k = 1; k < RL; k++) begin
            pv[k] <= pv[k-1];
            pa[k] <= pa[k-1];
        end
    end

    assign mem_rdata = (pv[RL-1] !== 1'b1) ? 16'hDEAD :
                       (tb_wr[pa[RL-1]] ? tb_mem[pa[RL-1]] : init_val(pa[RL-1]));

    typedef struct {
        logic [2:0]    strb;   // {we, re, done}
        logic [AW-1:0] addr;
        logic [WW-1:0] data;
        int            cyc;
        logic          err;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  errors = 0;

    logic [WW-1:0] ref_mem [2048];
    bit            ref_wr  [2048];
    logic [WW-1:0] bk_mem  [2048];
    bit            bk_wr   [2048];

    function automatic logic [AW-1:0] ref_addr(input int unsigned base, input int unsigned idx);
        int unsigned a;
        a = (base + (idx << S)) % 2048;
        return a[AW-1:0];
    endfunction

    function automatic logic [WW-1:0] ref_read(input logic [AW-1:0] a);
        return ref_wr[a] ? ref_mem[a] : init_val(a);
    endfunction

    function automatic void ref_write(input logic [AW-1:0] a, input logic [WW-1:0] d);
        ref_mem[a] = d;
        ref_wr[a]  = 1'b1;
    endfunction

    function automatic void push_ev(input logic [2:0] s, input logic [AW-1:0] a,
                                    input logic [WW-1:0] d, input int c, input logic e);
        ev_t ev;
        ev.strb = s; ev.addr = a; ev.data = d; ev.cyc = c; ev.err = e;
        exp_q.push_back(ev);
    endfunction

    // One update, start accepted in cycle c: predicts the full access sequence and its timing.
    function automatic void model_run(input int c, input int unsigned node, input int unsigned cl,
                                      input int unsigned bh, input int unsigned act);
        logic [AW-1:0] a;
        logic [WW-1:0] v;
        int            t;
`ifdef REWARD_BOUNDS_CHECK_EN
        if (cl >= MI || bh + NW - 1 >= MI || act >= MI) begin
            push_ev(3'b001, '0, '0, c + 1, 1'b1);
            return;
        end
`endif
        a = ref_addr(NB, cl);
        push_ev(3'b100, a, node[15:0], c + 1, 1'b0);
        ref_write(a, node[15:0]);
        for (int i = 0; i < NW; i++) begin
            t = c + 2 + i * (RL + 2);
            a = ref_addr(QB, bh + i);
            v = ref_read(a);
            push_ev(3'b010, a, '0, t, 1'b0);
            a = ref_addr(PB, act * (NW + 1) + i);
            push_ev(3'b100, a, v, t + RL + 1, 1'b0);
            ref_write(a, v);
        end
        a = ref_addr(PB, act * (NW + 1) + NW);
        push_ev(3'b100, a, cl[15:0], c + 2 + NW * (RL + 2), 1'b0);
        ref_write(a, cl[15:0]);
        push_ev(3'b001, '0, '0, c + LAT, 1'b0);
    endfunction

    task automatic monitor_loop();
        ev_t e;
        bit  ok;
        forever begin
            @(negedge clock);
            if (nrst === 1'b1 && (mem_we !== 1'b0 || mem_re !== 1'b0 || done !== 1'b0)) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_event cyc=%0d we=%b re=%b done=%b addr=%h, required no activity",
                             cyc, mem_we, mem_re, done, mem_addr);
                end else begin
                    e  = exp_q.pop_front();
                    ok = ({mem_we, mem_re, done} === e.strb) && (cyc == e.cyc);
                    if (e.strb != 3'b001 && mem_addr !== e.addr) ok = 0;
                    if (e.strb == 3'b100 && mem_wdata !== e.data) ok = 0;
                    if (e.strb == 3'b001 && err !== e.err) ok = 0;
                    if (!ok) begin
                        errors++;
                        $display("FAIL access_seq got cyc=%0d wre=%b addr=%h wdata=%h err=%b, required cyc=%0d wre=%b addr=%h wdata=%h err=%b",
                                 cyc, {mem_we, mem_re, done}, mem_addr, mem_wdata, err,
                                 e.cyc, e.strb, e.addr, e.data, e.err);
                    end
                end
            end
        end
    endtask

    task automatic launch(input logic [WW-1:0] n, input logic [WW-1:0] cl, input logic [WW-1:0] bh,
                          input logic [WW-1:0] act, input bit hold);
        @(negedge clock);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL idle_status busy=%b done=%b, required 0 0", busy, done);
        end
        my_node_id = n; my_cluster_id = cl; besthop = bh; action = act;
        start = 1'b1;
        model_run(cyc, n, cl, bh, act);
        if (!hold) begin
            @(negedge clock);
            start = 1'b0;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(negedge clock);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout pending=%0d, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic check_all_zero(input string name);
        checks++;
        if ({mem_addr, mem_wdata, mem_we, mem_re, busy, done, err} !== '0) begin
            errors++;
            $display("FAIL %s addr=%h wdata=%h we=%b re=%b busy=%b done=%b err=%b, required all 0",
                     name, mem_addr, mem_wdata, mem_we, mem_re, busy, done, err);
        end
    endtask

    initial begin
        int c0;
        nrst = 1'b0; start = 1'b0;
        my_node_id = '0; my_cluster_id = '0; action = '0; besthop = '0;
        fork
            monitor_loop();
        join_none

        #23;
        check_all_zero("reset_outputs");
        #4 nrst = 1'b1;

        // directed default case
        launch(16'd5, 16'd3, 16'd2, 16'd1, 1'b0);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_in_run busy=%b, required 1", busy);
        end
        drain();

        // randomized updates, mostly in-range indices with occasional overflow
        for (int r = 0; r < 12; r++) begin
            launch(16'($urandom), 16'($urandom_range(0, 70)), 16'($urandom_range(0, 66)),
                   16'($urandom_range(0, 70)), 1'b0);
            drain();
        end
        for (int r = 0; r < 3; r++) begin
            launch(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 1'b0);
            drain();
        end

        // besthop near the top of the index range: addresses wrap
        launch(16'h0007, 16'd9, 16'h03FF, 16'd20, 1'b0);
        drain();

        // start pulsed while busy is ignored
        launch(16'hBEEF, 16'd4, 16'd10, 16'd2, 1'b0);
        repeat (4) @(negedge clock);
        my_node_id = 16'h1111; my_cluster_id = 16'd1; besthop = 16'd1; action = 16'd1;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        drain();

        // start held high: second run accepted the cycle after DONE
        launch(16'h0A0A, 16'd6, 16'd30, 16'd7, 1'b1);
        c0 = cyc;
        model_run(c0 + LAT + 1, 16'h0A0A, 16'd6, 16'd30, 16'd7);
        repeat (LAT + 2) @(negedge clock);
        start = 1'b0;
        drain();

        // asynchronous reset during RD_WAIT, then a full run
        bk_mem = ref_mem;
        bk_wr  = ref_wr;
        launch(16'h00C3, 16'd12, 16'd40, 16'd3, 1'b0);
        @(negedge clock);
        @(negedge clock);
        #2 nrst = 1'b0;
        #1 check_all_zero("async_reset_mid_run");
        exp_q.delete();
        ref_mem = bk_mem;
        ref_wr  = bk_wr;
        ref_write(ref_addr(NB, 12), 16'h00C3);
        #1 nrst = 1'b1;
        repeat (3) @(negedge clock);
        launch(16'h0042, 16'd12, 16'd40, 16'd3, 1'b0);
        drain();

`ifdef REWARD_BOUNDS_CHECK_EN
        launch(16'd1, 16'd2, 16'd3, 16'd64, 1'b0);
        drain();
        launch(16'd1, 16'd2, 16'd3, 16'd5, 1'b0);
        drain();
`endif

        repeat (5) @(negedge clock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
